aes128_iter_stream: RTL and testbench
=====================================

# aes128_iter_stream

Parametrised, iterative AES-128 encryption engine with a valid/ready streaming interface of configurable beat width. It accepts a 128-bit plaintext block and optional 128-bit cipher key over 16/BUS_BYTES beats and runs one full round per clock using on-the-fly key expansion. It returns the ciphertext over the same number of beats with output backpressure. It replaces the fixed byte-serial unrolled encryptor as the cipher core in the crypto datapath, and adds key reuse across blocks and flow control on both sides.

## Interface
- BUS_BYTES, 1: bytes per beat; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts an input beat this cycle.
- in_data  in  8*BUS_BYTES  plaintext beat.
- in_key  in  8*BUS_BYTES  cipher key beat; ignored when the block's load_key is 0.
- load_key  in  1  sampled on the first beat of a block: 1 = load a new key from in_key, 0 = reuse the stored key.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  8*BUS_BYTES  ciphertext beat.
- busy  out  1  high in ROUND and OUT states.

## Operation
- Byte order follows FIPS-197. State byte 0 is bits 127:120.
  - The first beat carries the most-significant BUS_BYTES bytes; within a beat, the MSB byte is the lower state index.
  - Output uses the same order.
- NB = 16/BUS_BYTES beats per block. A beat counter runs 0..NB-1 and wraps to 0 after the last beat.
- FSM states are LOAD, ROUND, OUT.
- LOAD: in_ready=1.
  - Each handshake (in_valid & in_ready) shifts the beat into the plaintext register and, if the block's load_key is set, into the key register.
  - load_key is latched on beat 0 and applied to every beat of that block.
  - On the handshake of beat NB-1:
    - state <= plaintext ^ K0, where K0 is the new key if loading, otherwise the stored base key.
    - The round key register <= K0 and rcon <= 0x01.
    - round <= 1, FSM -> ROUND.
  - When NB=1, the single beat is also the last beat.
- ROUND: one round per cycle, round = 1..10.
  - Next round key = KeyExpansion(round key, rcon).
  - Rounds 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ next key.
  - Round 10: MixColumns is omitted.
  - rcon <= xtime(rcon), which gives 0x1b after 0x80 and 0x36 at round 10.
  - After round 10, FSM -> OUT and the beat counter is at 0.
- The base key register changes only on a key-loading block. The round key register is scratch.
- OUT: out_valid=1 and out_data = ciphertext beat[counter].
  - Each out_ready handshake advances the counter.
  - With out_ready low, out_data and out_valid hold stable.
  - The handshake of beat NB-1 moves FSM -> LOAD.
- in_ready is 0 in ROUND and OUT. Input and output never overlap.
- out_data is 0 whenever out_valid is 0.
- Key reuse with no key ever loaded since reset uses an all-zero base key.

## Timing
- During rst and after reset:
  - While rst is high, in_ready=0, out_valid=0, out_data=0, busy=0.
  - FSM=LOAD, counter=0, base key=0.
  - in_ready=1 from the first cycle after rst falls.
- rst asserted mid-block, in any state: the partial block is discarded with no output and all registers return to their reset values on that edge.
- Latency:
  - Last input handshake at edge T.
  - Rounds complete at edges T+1..T+10.
  - out_valid is high from the cycle after edge T+10, i.e. the first output beat is available 10 cycles after the last input edge.
- Minimum block period is NB + 10 + NB cycles when out_ready is held high. Next block's beat 0 can be accepted in the cycle after the last output handshake.
- in_valid=0 gaps in LOAD pause the counter. No timeout applies.
- out_ready is not sampled outside OUT. in_valid and in_key are not sampled outside LOAD.
- Arithmetic:
  - GF(2^8) uses polynomial 0x11b.
  - The S-box is combinational: 16 for state plus 4 for the key schedule.
  - All datapaths are 128 bits wide; there are no partial-width operations.

## Test plan
- BUS_BYTES=1, load_key=1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Expect out bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a in that order.
  - First out_valid exactly 10 cycles after the 16th input edge.
- BUS_BYTES=4, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Expect words 3925841d, 02dc09fb, dc118597, 196a0b32.
  - Then send a second block with load_key=0 and pt 00000000000000000000000000000000.
  - Expect ciphertext equal to a reference model using the same key. in_key is driven to garbage on this block and must have no effect.
- BUS_BYTES=16, all-zero key and pt, load_key=1.
  - Expect 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - in_ready=0 for the 10 round cycles and while out_valid is high.
- Backpressure with BUS_BYTES=2: hold out_ready=0 for 5 cycles on beat 3, and insert random in_valid gaps.
  - out_data must stay constant while stalled.
  - The output sequence must match the FIPS-197 C.1 ciphertext.
- Reset mid-operation:
  - Assert rst during round 5. Outputs go to reset values on the next edge and no out_valid appears.
  - Then run a block with load_key=0. It must use the zero key, giving ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e for a zero pt.

Source files
------------

// File: rtl/aes128_iter_stream.sv
// aes128_iter_stream
//   Iterative AES-128 encryptor: one full round per clock, round keys are
//   expanded on the fly. Plaintext and key arrive over NB = 16/BUS_BYTES
//   beats on a valid/ready input port, and ciphertext leaves over NB beats
//   on a valid/ready output port. The base key is kept across blocks, so a
//   block with load_key=0 reuses the most recently loaded key.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input beat handshake
//   in_data, in_key       plaintext / key beat (MSB byte = lower state index)
//   load_key              sampled on beat 0: 1 = take key from in_key
//   out_valid/out_ready   output beat handshake
//   out_data              ciphertext beat, zero when out_valid is low
//   busy                  high while rounds run or output is pending
module aes128_iter_stream #(
   parameter int BUS_BYTES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*BUS_BYTES-1:0] in_data,
   input  logic [8*BUS_BYTES-1:0] in_key,
   input  logic                   load_key,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*BUS_BYTES-1:0] out_data,
   output logic                   busy
);
   localparam int W  = 8 * BUS_BYTES;
   localparam int NB = 16 / BUS_BYTES;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   generate
      if (BUS_BYTES != 1 && BUS_BYTES != 2 && BUS_BYTES != 4 &&
          BUS_BYTES != 8 && BUS_BYTES != 16) begin : g_bad_bus_bytes
         $error("aes128_iter_stream: BUS_BYTES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {LOAD, ROUND, OUT} fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the
   // FIPS-197 affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;
      p2   = gmul(x, x);
      p4   = gmul(p2, p2);
      p8   = gmul(p4, p4);
      p16  = gmul(p8, p8);
      p32  = gmul(p16, p16);
      p64  = gmul(p32, p32);
      p128 = gmul(p64, p64);
      inv  = gmul(gmul(gmul(p2, p4), gmul(p8, p16)), gmul(gmul(p32, p64), p128));
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   fsm_t            fsm_reg;
   logic [CW-1:0]   cnt_reg;
   logic [127:0]    pt_reg, key_reg, rk_reg, st_reg;
   logic [7:0]      rcon_reg;
   logic [3:0]      round_reg;
   logic            lk_reg;
   logic            in_ready_reg, out_valid_reg, busy_reg;
   logic [W-1:0]    out_data_reg;

   // ---------------- round datapath ----------------
   logic [7:0]   sb [16];
   logic [7:0]   sr [16];
   logic [127:0] sr_flat, mc_flat, rk_next, st_next;
   logic [31:0]  rot_w3, sub_w3, ks_t;
   genvar gi;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub_shift
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         assign sb[gi] = sbox(st_reg[127-8*gi -: 8]);
         // state byte index is 4*col + row; row r rotates left by r columns
         assign sr[gi] = sb[4*((COL + ROW) % 4) + ROW];
         assign sr_flat[127-8*gi -: 8] = sr[gi];
      end
      for (gi = 0; gi < 4; gi++) begin : g_mix
         logic [7:0] a0, a1, a2, a3;
         assign a0 = sr[4*gi];
         assign a1 = sr[4*gi+1];
         assign a2 = sr[4*gi+2];
         assign a3 = sr[4*gi+3];
         assign mc_flat[127-32*gi -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         assign mc_flat[119-32*gi -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         assign mc_flat[111-32*gi -: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         assign mc_flat[103-32*gi -: 8]  = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      for (gi = 0; gi < 4; gi++) begin : g_key_sbox
         assign sub_w3[31-8*gi -: 8] = sbox(rot_w3[31-8*gi -: 8]);
      end
   endgenerate

   assign rot_w3 = {rk_reg[23:0], rk_reg[31:24]};
   assign ks_t   = sub_w3 ^ {rcon_reg, 24'h000000};
   assign rk_next[127:96] = rk_reg[127:96] ^ ks_t;
   assign rk_next[95:64]  = rk_reg[95:64]  ^ rk_next[127:96];
   assign rk_next[63:32]  = rk_reg[63:32]  ^ rk_next[95:64];
   assign rk_next[31:0]   = rk_reg[31:0]   ^ rk_next[63:32];
   assign st_next = ((round_reg == 4'd10) ? sr_flat : mc_flat) ^ rk_next;

   // ---------------- input assembly ----------------
   logic          lk_eff, cnt_last, in_hs;
   logic [127:0]  pt_shift, key_shift, k0, st_shl;

   // load_key is only meaningful on beat 0; later beats use the latched copy
   assign lk_eff    = (cnt_reg == '0) ? load_key : lk_reg;
   assign cnt_last  = (cnt_reg == CW'(NB - 1));
   assign in_hs     = in_valid && in_ready_reg;
   assign pt_shift  = 128'({pt_reg, in_data});
   assign key_shift = 128'({key_reg, in_key});
   assign k0        = lk_eff ? key_shift : key_reg;
   assign st_shl    = st_reg << W;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_reg       <= LOAD;
         cnt_reg       <= '0;
         pt_reg        <= '0;
         key_reg       <= '0;
         rk_reg        <= '0;
         st_reg        <= '0;
         rcon_reg      <= 8'h00;
         round_reg     <= 4'd0;
         lk_reg        <= 1'b0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         case (fsm_reg)
            LOAD: begin
               in_ready_reg <= 1'b1;
               if (in_hs) begin
                  pt_reg <= pt_shift;
                  if (lk_eff) key_reg <= key_shift;
                  if (cnt_reg == '0) lk_reg <= load_key;
                  if (cnt_last) begin
                     cnt_reg      <= '0;
                     st_reg       <= pt_shift ^ k0;
                     rk_reg       <= k0;
                     rcon_reg     <= 8'h01;
                     round_reg    <= 4'd1;
                     in_ready_reg <= 1'b0;
                     busy_reg     <= 1'b1;
                     fsm_reg      <= ROUND;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            ROUND: begin
               st_reg    <= st_next;
               rk_reg    <= rk_next;
               rcon_reg  <= xtime(rcon_reg);
               round_reg <= round_reg + 4'd1;
               if (round_reg == 4'd10) begin
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= st_next[127 -: W];
                  fsm_reg       <= OUT;
               end
            end
            OUT: begin
               // ciphertext drains from the top of st_reg, one beat per handshake
               if (out_ready) begin
                  st_reg <= st_shl;
                  if (cnt_last) begin
                     cnt_reg       <= '0;
                     out_valid_reg <= 1'b0;
                     out_data_reg  <= '0;
                     busy_reg      <= 1'b0;
                     in_ready_reg  <= 1'b1;
                     fsm_reg       <= LOAD;
                  end else begin
                     cnt_reg      <= cnt_reg + 1'b1;
                     out_data_reg <= st_shl[127 -: W];
                  end
               end
            end
            default: fsm_reg <= LOAD;
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign busy      = busy_reg;
endmodule

// File: tb/tb_aes128_iter_stream.sv
// tb_aes128_iter_stream
//   Four engines (BUS_BYTES = 1, 2, 4, 16) share clk/rst and are exercised
//   one at a time with known-answer vectors. Stimulus pushes expected output
//   beats into a scoreboard queue; a negedge monitor pops and compares each
//   output handshake and also checks idle-zero and stall-hold behaviour.
module tb_aes128_iter_stream;
   localparam int NI = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NI-1:0]   in_valid  = '0;
   logic [NI-1:0]   load_key  = '0;
   logic [NI-1:0]   out_ready = '1;
   logic [127:0]    in_data [NI];
   logic [127:0]    in_key  [NI];
   wire  [NI-1:0]   in_ready;
   wire  [NI-1:0]   out_valid;
   wire  [NI-1:0]   busy;
   wire  [127:0]    out_data [NI];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int           inst;
      logic [127:0] beat;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   function automatic int bb_of(input int idx);
      return (idx == 0) ? 1 : (idx == 1) ? 2 : (idx == 2) ? 4 : 16;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         localparam int BBI = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 16;
         wire [8*BBI-1:0] od;
         aes128_iter_stream #(.BUS_BYTES(BBI)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi][8*BBI-1:0]),
            .in_key    (in_key[gi][8*BBI-1:0]),
            .load_key  (load_key[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (od),
            .busy      (busy[gi])
         );
         assign out_data[gi] = 128'(od);
      end
   endgenerate

   task automatic check(input string name, input int inst, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
      end
   endtask

   function automatic logic [127:0] beat_of(input logic [127:0] v, input int bb, input int j);
      return (v << (8 * bb * j)) >> (128 - 8 * bb);
   endfunction

   task automatic push_expect(input int idx, input logic [127:0] ct);
      exp_t e;
      for (int j = 0; j < 16 / bb_of(idx); j++) begin
         e.inst = idx;
         e.beat = beat_of(ct, bb_of(idx), j);
         exp_q.push_back(e);
      end
   endtask

   // ---------------- monitor ----------------
   logic [127:0] held   [NI];
   logic [NI-1:0] held_v = '0;
   bit           mon_en = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         held_v <= '0;
      end else if (mon_en) begin
         for (int i = 0; i < NI; i++) begin
            if (!out_valid[i])
               check("idle_out_data_zero", i, out_data[i], 128'h0);
            if (held_v[i])
               check("stall_hold", i, {out_valid[i], out_data[i][126:0]},
                     {1'b1, held[i][126:0]});
            if (out_valid[i] && out_ready[i]) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", i, {127'h0, out_valid[i]}, 128'h0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("out_inst", i, 128'(i), 128'(e.inst));
                  check("out_beat", i, out_data[i], e.beat);
                  $display("beat inst%0d data %h", i, out_data[i]);
               end
            end
            held_v[i] <= out_valid[i] && !out_ready[i];
            held[i]   <= out_data[i];
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_beat(input int idx, input logic [127:0] d, input logic [127:0] k,
                            input logic lk);
      int n = 0;
      in_valid[idx] = 1'b1;
      in_data[idx]  = d;
      in_key[idx]   = k;
      load_key[idx] = lk;
      @(negedge clk);
      while (!in_ready[idx] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[idx]) check("in_ready_timeout", idx, 128'(in_ready[idx]), 128'h1);
      @(posedge clk);
      #1;
      in_valid[idx] = 1'b0;
      load_key[idx] = 1'bx;
   endtask

   // Later beats drive load_key inverted and, when reusing, garbage in_key.
   task automatic send_block(input int idx, input logic [127:0] key, input logic [127:0] pt,
                             input logic lk, input bit gaps);
      int bb = bb_of(idx);
      logic [127:0] junk;
      for (int j = 0; j < 16 / bb; j++) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
         #0;
         junk = {$urandom, $urandom, $urandom, $urandom};
         send_beat(idx, beat_of(pt, bb, j), lk ? beat_of(key, bb, j) : junk,
                   (j == 0) ? lk : !lk);
      end
      $display("block sent inst%0d pt %h load_key %0d", idx, pt, lk);
   endtask

   // Called right after the last input edge T; checks the first output appears after edge T+10.
   task automatic wait_first_out(input int idx, input bit chk_round);
      int k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (chk_round && !out_valid[idx]) begin
            check("round_in_ready", idx, 128'(in_ready[idx]), 128'h0);
            check("round_busy", idx, 128'(busy[idx]), 128'h1);
         end
      end while (!out_valid[idx] && k < 40);
      check("first_out_latency", idx, 128'(k), 128'd10);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      check("drain", 0, 128'(exp_q.size()), 128'h0);
      @(posedge clk);
      #1;
   endtask

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CT_B0  = 128'h7df76b0c1ab899b33e42f047b91b546f;
   localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      for (int i = 0; i < NI; i++) begin
         in_data[i] = '0;
         in_key[i]  = '0;
      end
      // reset values while rst is high
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("rst_in_ready", i, 128'(in_ready[i]), 128'h0);
         check("rst_out_valid", i, 128'(out_valid[i]), 128'h0);
         check("rst_out_data", i, out_data[i], 128'h0);
         check("rst_busy", i, 128'(busy[i]), 128'h0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
         check("post_rst_in_ready", i, 128'(in_ready[i]), 128'h1);

      // byte-serial FIPS-197 C.1 with exact latency
      push_expect(0, CT_C1);
      send_block(0, KEY_C1, PT_C1, 1'b1, 1'b0);
      wait_first_out(0, 1'b1);
      wait_drain();

      // 32-bit beats: FIPS-197 B, then key reuse with garbage in_key
      push_expect(2, CT_B);
      send_block(2, KEY_B, PT_B, 1'b1, 1'b0);
      wait_first_out(2, 1'b0);
      wait_drain();
      push_expect(2, CT_B0);
      send_block(2, 128'h0, 128'h0, 1'b0, 1'b0);
      wait_first_out(2, 1'b0);
      wait_drain();

      // full-width beat; in_ready stays low while output is pending
      out_ready[3] = 1'b0;
      push_expect(3, CT_Z);
      send_block(3, 128'h0, 128'h0, 1'b1, 1'b0);
      wait_first_out(3, 1'b1);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("out_in_ready", 3, 128'(in_ready[3]), 128'h0);
         check("out_valid_held", 3, 128'(out_valid[3]), 128'h1);
      end
      out_ready[3] = 1'b1;
      wait_drain();

      // 16-bit beats with input gaps and a 5-cycle stall on output beat 3
      out_ready[1] = 1'b0;
      push_expect(1, CT_C1);
      send_block(1, KEY_C1, PT_C1, 1'b1, 1'b1);
      wait_first_out(1, 1'b0);
      for (int b = 0; b < 8; b++) begin
         if (b == 3) repeat (5) begin
            @(posedge clk);
            #1;
         end
         out_ready[1] = 1'b1;
         @(posedge clk);
         #1;
         out_ready[1] = 1'b0;
      end
      out_ready[1] = 1'b1;
      wait_drain();

      // reset during round 5 discards the block and clears the stored key
      send_block(2, KEY_B, PT_B, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_in_ready", 2, 128'(in_ready[2]), 128'h0);
      check("midrst_out_valid", 2, 128'(out_valid[2]), 128'h0);
      check("midrst_out_data", 2, out_data[2], 128'h0);
      check("midrst_busy", 2, 128'(busy[2]), 128'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         check("midrst_no_out", 2, 128'(out_valid[2]), 128'h0);
      end
      push_expect(2, CT_Z);
      send_block(2, 128'h0, 128'h0, 1'b0, 1'b0);
      wait_first_out(2, 1'b0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
